// File: rtl/audio_mix_filter.sv
// Stereo FM + PSG mixer with saturation, one-pole IIR smoothing and gain stage,
// producing offset-binary words once per DAC frame. Optional macro AUDIO_MUTE_RAMP_EN.
module audio_mix_filter #(
    parameter int FM_W      = 14,
    parameter int PSG_W     = 11,
    parameter int PSG_SHIFT = 3,
    parameter int K         = 3,
    parameter int DIV       = 32
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic [FM_W-1:0]  fm_l,
    input  logic [FM_W-1:0]  fm_r,
    input  logic             fm_strobe,
    input  logic [PSG_W-1:0] psg,
    input  logic             psg_strobe,
    input  logic             mute,
    output logic             sample_tick,
    output logic [15:0]      dout_l,
    output logic [15:0]      dout_r
);

    localparam int ACC_W = 16 + K;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [PSG_W-1:0] PSG_CTR   = {1'b1, {(PSG_W-1){1'b0}}};
    localparam logic [8:0]       GAIN_FULL = 9'd256;

    function automatic logic signed [17:0] mix_sum(input logic [FM_W-1:0]  fm,
                                                   input logic [PSG_W-1:0] p);
        logic signed [17:0] xf;
        logic signed [17:0] xp;
        xf = 18'(signed'(fm)) <<< (16 - FM_W);
        xp = (signed'(18'(p)) - signed'(18'(PSG_CTR))) <<< PSG_SHIFT;
        return xf + xp;
    endfunction

    function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
        if (v > 18'sd32767)
            return 16'sh7FFF;
        else if (v < -18'sd32768)
            return 16'sh8000;
        else
            return 16'(v);
    endfunction

    // Leak of acc >>> K balances the input exactly when acc >>> K == s, so no bias.
    function automatic logic signed [ACC_W-1:0] iir_step(input logic signed [ACC_W-1:0] acc,
                                                         input logic signed [15:0]      s);
        return acc + ACC_W'(s) - (acc >>> K);
    endfunction

    function automatic logic [15:0] scale_out(input logic signed [ACC_W-1:0] acc,
                                              input logic [8:0]              g);
        logic signed [15:0] y;
        logic signed [25:0] prod;
        y    = 16'(acc >>> K);
        prod = 26'(y) * signed'(26'(g));
        return 16'(prod >>> 8) ^ 16'h8000;
    endfunction

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    tick_q, tick_d;
    logic [FM_W-1:0]         fm_l_q, fm_l_d, fm_r_q, fm_r_d;
    logic [PSG_W-1:0]        psg_q, psg_d;
    logic signed [15:0]      mix_l_p1_q, mix_l_p1_d, mix_r_p1_q, mix_r_p1_d;
    logic                    vld_p1_q, vld_p1_d;
    logic signed [ACC_W-1:0] acc_l_p2_q, acc_l_p2_d, acc_r_p2_q, acc_r_p2_d;
    logic [8:0]              gain_p2_q, gain_p2_d;
    logic                    vld_p2_q, vld_p2_d;
    logic [15:0]             dout_l_q, dout_l_d, dout_r_q, dout_r_d;

    always_comb begin
        cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        tick_d = (cnt_d == CNT_LAST);

        fm_l_d = fm_strobe  ? fm_l : fm_l_q;
        fm_r_d = fm_strobe  ? fm_r : fm_r_q;
        psg_d  = psg_strobe ? psg  : psg_q;

        // Stage 1: mix held samples (pre-strobe values) and clamp to 16 bits
        mix_l_p1_d = tick_q ? sat16(mix_sum(fm_l_q, psg_q)) : mix_l_p1_q;
        mix_r_p1_d = tick_q ? sat16(mix_sum(fm_r_q, psg_q)) : mix_r_p1_q;
        vld_p1_d   = tick_q;

        // Stage 2: IIR update and gain selection
        acc_l_p2_d = vld_p1_q ? iir_step(acc_l_p2_q, mix_l_p1_q) : acc_l_p2_q;
        acc_r_p2_d = vld_p1_q ? iir_step(acc_r_p2_q, mix_r_p1_q) : acc_r_p2_q;
        vld_p2_d   = vld_p1_q;
`ifdef AUDIO_MUTE_RAMP_EN
        gain_p2_d = gain_p2_q;
        if (vld_p1_q) begin
            if (mute && gain_p2_q != 9'd0)
                gain_p2_d = gain_p2_q - 9'd1;
            else if (!mute && gain_p2_q != GAIN_FULL)
                gain_p2_d = gain_p2_q + 9'd1;
        end
`else
        gain_p2_d = vld_p1_q ? (mute ? 9'd0 : GAIN_FULL) : gain_p2_q;
`endif

        // Stage 3: gain and offset-binary conversion, held for the rest of the frame
        dout_l_d = vld_p2_q ? scale_out(acc_l_p2_q, gain_p2_q) : dout_l_q;
        dout_r_d = vld_p2_q ? scale_out(acc_r_p2_q, gain_p2_q) : dout_r_q;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cnt_q      <= '0;
            tick_q     <= 1'b0;
            fm_l_q     <= '0;
            fm_r_q     <= '0;
            psg_q      <= PSG_CTR;
            mix_l_p1_q <= '0;
            mix_r_p1_q <= '0;
            vld_p1_q   <= 1'b0;
            acc_l_p2_q <= '0;
            acc_r_p2_q <= '0;
            gain_p2_q  <= GAIN_FULL;
            vld_p2_q   <= 1'b0;
            dout_l_q   <= 16'h8000;
            dout_r_q   <= 16'h8000;
        end else begin
            cnt_q      <= cnt_d;
            tick_q     <= tick_d;
            fm_l_q     <= fm_l_d;
            fm_r_q     <= fm_r_d;
            psg_q      <= psg_d;
            mix_l_p1_q <= mix_l_p1_d;
            mix_r_p1_q <= mix_r_p1_d;
            vld_p1_q   <= vld_p1_d;
            acc_l_p2_q <= acc_l_p2_d;
            acc_r_p2_q <= acc_r_p2_d;
            gain_p2_q  <= gain_p2_d;
            vld_p2_q   <= vld_p2_d;
            dout_l_q   <= dout_l_d;
            dout_r_q   <= dout_r_d;
        end
    end

    assign sample_tick = tick_q;
    assign dout_l      = dout_l_q;
    assign dout_r      = dout_r_q;

endmodule

// File: tb/tb_audio_mix_filter.sv
// Self-checking bench for audio_mix_filter (default build, mute ramp disabled):
// frame-level reference model, steady-state vector table, corner sequences, random traffic.
module tb_audio_mix_filter;

    localparam int DIVC = 32;

    logic        clk = 1'b0;
    logic        n_reset;
    logic [13:0] fm_l, fm_r;
    logic        fm_strobe;
    logic [10:0] psg;
    logic        psg_strobe;
    logic        mute;
    logic        sample_tick;
    logic [15:0] dout_l, dout_r;

    always #5 clk = ~clk;

    audio_mix_filter dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .fm_l        (fm_l),
        .fm_r        (fm_r),
        .fm_strobe   (fm_strobe),
        .psg         (psg),
        .psg_strobe  (psg_strobe),
        .mute        (mute),
        .sample_tick (sample_tick),
        .dout_l      (dout_l),
        .dout_r      (dout_r)
    );

    int checks = 0;
    int errors = 0;

    // reference model state
    int  m_cyc;
    int  h_fm_l, h_fm_r, h_psg;
    int  s_l, s_r, acc_l, acc_r, gain;
    int  m_dout_l, m_dout_r;
    bit  have_snap, have_acc;

    typedef struct {
        int          fl;
        int          fr;
        int          p;
        logic [15:0] el;
        logic [15:0] er;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, m_cyc);
        end
    endtask

    function automatic int fdiv(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
        return q;
    endfunction

    function automatic int mix_model(input int fm, input int p);
        int s;
        s = fm * 4 + (p - 1024) * 8;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return s;
    endfunction

    function automatic int out_model(input int acc, input int g);
        int y;
        y = fdiv(acc, 8);
        return (fdiv(y * g, 256) + 32768) & 32'hFFFF;
    endfunction

    task automatic model_reset();
        m_cyc = 0;
        h_fm_l = 0; h_fm_r = 0; h_psg = 1024;
        s_l = 0; s_r = 0; acc_l = 0; acc_r = 0; gain = 256;
        m_dout_l = 32'h8000; m_dout_r = 32'h8000;
        have_snap = 0; have_acc = 0;
    endtask

    // One rising edge ending cycle m_cyc; tick cycle is phase DIVC-1.
    task automatic model_edge();
        int ph;
        ph = m_cyc % DIVC;
        if (ph == 1 && have_acc) begin
            m_dout_l = out_model(acc_l, gain);
            m_dout_r = out_model(acc_r, gain);
        end
        if (ph == 0 && have_snap) begin
            acc_l = acc_l + s_l - fdiv(acc_l, 8);
            acc_r = acc_r + s_r - fdiv(acc_r, 8);
            gain  = mute ? 0 : 256;
            have_acc = 1;
        end
        if (ph == DIVC - 1) begin
            s_l = mix_model(h_fm_l, h_psg);
            s_r = mix_model(h_fm_r, h_psg);
            have_snap = 1;
        end
        if (fm_strobe) begin
            h_fm_l = int'($signed(fm_l));
            h_fm_r = int'($signed(fm_r));
        end
        if (psg_strobe) h_psg = int'(psg);
        m_cyc++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("tick", int'(sample_tick), int'((m_cyc % DIVC) == DIVC - 1));
        chk("dout_l", int'(dout_l), m_dout_l);
        chk("dout_r", int'(dout_r), m_dout_r);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic goto_phase(input int p);
        for (int i = 0; i < DIVC && (m_cyc % DIVC) != p; i++) step();
    endtask

    task automatic strobe_all(input int fl, input int fr, input int p);
        fm_l = 14'(fl); fm_r = 14'(fr); psg = 11'(p);
        fm_strobe = 1'b1; psg_strobe = 1'b1;
        step();
        fm_strobe = 1'b0; psg_strobe = 1'b0;
    endtask

    // Called right after reset release: first tick spacing and first IIR output from acc = 0.
    task automatic first_frame(input string tag);
        int edges;
        strobe_all(4096, 0, 1024);
        edges = 1;
        while (!sample_tick && edges < 40) begin
            step();
            edges++;
        end
        chk({tag, "_first_tick_edge"}, edges, 31);
        step();
        chk({tag, "_T1_hold"}, int'(dout_l), 'h8000);
        step();
        chk({tag, "_T2_hold"}, int'(dout_l), 'h8000);
        step();
        chk({tag, "_first_update_l"}, int'(dout_l), 'h8800);
        chk({tag, "_first_update_r"}, int'(dout_r), 'h8000);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4096,   0,     1024, 16'hC000, 16'h8000};
        vecs[1] = '{8191,  -8192,  2047, 16'hFFFF, 16'h1FF8};
        vecs[2] = '{-8192, -8192,  0,    16'h0000, 16'h0000};
        vecs[3] = '{0,      100,   1029, 16'h8028, 16'h81B8};
        vecs[4] = '{-1,     1,     1024, 16'h7FFC, 16'h8004};
        vecs[5] = '{2000,  -3000,  900,  16'h9B60, 16'h4D40};

        n_reset = 1'b0; fm_l = '0; fm_r = '0; psg = '0;
        fm_strobe = 1'b0; psg_strobe = 1'b0; mute = 1'b0;
        model_reset();
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("reset_dout_l", int'(dout_l), 'h8000);
        chk("reset_dout_r", int'(dout_r), 'h8000);
        chk("reset_tick", int'(sample_tick), 0);

        n_reset = 1'b1;
        model_reset();
        first_frame("boot");

        run(127 * DIVC);
        chk("step128_l", int'(dout_l), 'hC000);
        chk("step128_r", int'(dout_r), 'h8000);

        // strobe coincident with tick is used one frame later
        goto_phase(DIVC - 1);
        fm_l = 14'(-4096); fm_strobe = 1'b1;
        step();
        fm_strobe = 1'b0;
        step(); step();
        chk("coincident_hold", int'(dout_l), 'hC000);
        goto_phase(DIVC - 1);
        step(); step(); step();
        chk("coincident_next", int'(dout_l), 'hB000);

        for (int v = 0; v < 6; v++) begin
            strobe_all(vecs[v].fl, vecs[v].fr, vecs[v].p);
            run(140 * DIVC);
            chk($sformatf("vec%0d_l", v), int'(dout_l), int'(vecs[v].el));
            chk($sformatf("vec%0d_r", v), int'(dout_r), int'(vecs[v].er));
        end

        // mute: output silent at next update, IIR keeps tracking underneath
        strobe_all(4096, 0, 1024);
        run(140 * DIVC);
        chk("premute", int'(dout_l), 'hC000);
        goto_phase(2);
        mute = 1'b1;
        goto_phase(DIVC - 1);
        step(); step(); step();
        chk("mute_next_l", int'(dout_l), 'h8000);
        chk("mute_next_r", int'(dout_r), 'h8000);
        run(3 * DIVC);
        chk("mute_held", int'(dout_l), 'h8000);
        mute = 1'b0;
        run(DIVC);
        chk("unmute", int'(dout_l), 'hC000);
        mute = 1'b1;
        strobe_all(-4096, 0, 1024);
        run(140 * DIVC);
        chk("mute_track_silent", int'(dout_l), 'h8000);
        mute = 1'b0;
        run(DIVC);
        chk("mute_track_restore", int'(dout_l), 'h4000);

        // asynchronous reset in the middle of a frame while converging
        strobe_all(8191, 0, 2047);
        run(5 * DIVC);
        goto_phase(17);
        chk("prereset_nonsilent", int'(dout_l != 16'h8000), 1);
        n_reset = 1'b0;
        #1;
        chk("midreset_l", int'(dout_l), 'h8000);
        chk("midreset_r", int'(dout_r), 'h8000);
        chk("midreset_tick", int'(sample_tick), 0);
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("midreset_hold_l", int'(dout_l), 'h8000);
        n_reset = 1'b1;
        model_reset();
        first_frame("rerun");

        // random traffic
        for (int f = 0; f < 30; f++) begin
            mute = ($urandom_range(0, 3) == 0);
            for (int c = 0; c < DIVC; c++) begin
                fm_strobe  = ($urandom_range(0, 7) == 0);
                psg_strobe = ($urandom_range(0, 7) == 0);
                fm_l = 14'($urandom);
                fm_r = 14'($urandom);
                psg  = 11'($urandom);
                step();
            end
        end
        fm_strobe = 1'b0; psg_strobe = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
